// File: rtl/cpu_fetch.sv
// cpu_fetch: LEGv8 instruction fetch unit.
// PC, imem req/ack, instruction register, redirect and HALT handling.
module cpu_fetch #(
    parameter int unsigned     ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [10:0]       inst31_21,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              halted
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        ISSUE  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [31:0]       ir_n;
    logic [ADDR_W-1:0] ipc_n;
    logic              discard, discard_n;
    logic [ADDR_W-1:0] target;
    logic              is_halt;
    logic              hold;

    assign target    = {branch_target[ADDR_W-1:2], 2'b00};
    assign is_halt   = (inst[31:21] == 11'h7FF);
    assign inst31_21 = inst[31:21];
    // Keep the address on the bus while a request is still waiting for ack.
    assign hold      = (state == FETCH) && imem_req && !imem_ack;

    // Next-state, next-PC and instruction register update.
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        ir_n      = inst;
        ipc_n     = inst_pc;
        discard_n = discard;
        unique case (state)
            FETCH: begin
                if (imem_req) begin
                    if (imem_ack) begin
                        discard_n = 1'b0;
                        if (branch_taken) begin
                            pc_n = target;
                        end else if (!discard) begin
                            ir_n    = imem_rdata;
                            ipc_n   = pc;
                            state_n = ISSUE;
                        end
                    end else if (branch_taken) begin
                        pc_n      = target;
                        discard_n = 1'b1;
                    end
                end else if (branch_taken) begin
                    pc_n = target;
                end
            end
            ISSUE: begin
                if (branch_taken) begin
                    pc_n    = target;
                    state_n = FETCH;
                end else if (inst_ready) begin
                    if (is_halt) begin
                        state_n = HALTED;
                    end else begin
                        pc_n    = pc + ADDR_W'(4);
                        state_n = FETCH;
                    end
                end
            end
            HALTED: begin
                state_n = HALTED;
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    // State and registered outputs; everything returns to reset values at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            discard    <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            inst_valid <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            discard    <= discard_n;
            inst       <= ir_n;
            inst_pc    <= ipc_n;
            imem_req   <= (state_n == FETCH);
            imem_addr  <= hold ? imem_addr : pc_n;
            inst_valid <= (state_n == ISSUE);
            halted     <= (state_n == HALTED);
        end
    end

endmodule
